// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared state encoding, default widths and helpers for sdram_port_arb
//
// Purpose: common definitions imported by rr_picker and sdram_port_arb.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, BURST, GAP)
//   ARB_PTR_W   : width of client indices (grant_port, round-robin pointer)
//   DEF_*       : default parameter values for the arbiter
//   ptr_next()  : round-robin successor of a client index
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BURST = 2'd2,
    ARB_GAP   = 2'd3
  } arb_state_e;

  // Client indices are 2 bits wide: up to four clients.
  localparam int ARB_PTR_W       = 2;

  localparam int DEF_NUM_PORTS   = 2;
  localparam int DEF_ADDR_W      = 24;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BLEN_W      = 10;
  localparam int DEF_ACK_TIMEOUT = 64;

  // Next client after ptr, wrapping at n clients.
  function automatic logic [ARB_PTR_W-1:0] ptr_next(input logic [ARB_PTR_W-1:0] ptr,
                                                    input int                   n);
    logic [ARB_PTR_W-1:0] last;
    last = ARB_PTR_W'(n - 1);
    return (ptr >= last) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority encoder
//
// Purpose: pick one requester, searching upward from ptr and wrapping.
// Ports:
//   req   in  N          : request vector, one bit per client
//   ptr   in  ARB_PTR_W  : client with highest priority this decision
//   gnt   out N          : one-hot grant (all zero when nothing requests)
//   valid out 1          : at least one request present
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int N = DEF_NUM_PORTS
) (
  input  logic [N-1:0]         req,
  input  logic [ARB_PTR_W-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 valid
);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    // Walk the rotated distance d = (j - ptr) mod N from 0 upward; the first
    // requester met is the winner, later ones are masked by valid.
    for (int d = 0; d < N; d++) begin
      for (int j = 0; j < N; j++) begin
        if (!valid && req[j] && (((j + N - int'(ptr)) % N) == d)) begin
          gnt[j] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// rtl/sdram_port_arb.sv - burst arbiter sharing one sdram_ctrl request port between FIFO clients
//
// Purpose: grants one client burst at a time to sdram_ctrl, holds the grant
// until the controller ack falls, and routes data/acks to the granted client.
// Optional build macro: ARB_GLOBAL_WR_PRIO_EN (any pending write beats every read).
// Ports (client p occupies slice p of each packed bus):
//   clk, rst                         : clock, synchronous active-high reset
//   port_wr_req/port_rd_req          : per-client burst requests
//   port_wr_addr/port_rd_addr        : per-client addresses (live, client increments during ack)
//   port_wr_blen/port_rd_blen        : per-client burst lengths
//   port_wr_data                     : per-client write data
//   port_wr_ack/port_rd_ack          : controller acks, granted client and direction only
//   port_rd_data                     : controller read data, broadcast
//   sdram_wr_req/sdram_rd_req        : registered requests to sdram_ctrl
//   sdram_*_addr/_blen, sdram_wr_data: granted client's request fields
//   sdram_wr_ack/sdram_rd_ack        : controller acks
//   sdram_rd_data                    : controller read data
//   grant_port/grant_rd              : current or last grant (client, 1 = read)
//   arb_busy                         : FSM not idle
//   timeout_err                      : one-cycle pulse when a grant is abandoned
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BLEN_W      = DEF_BLEN_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        port_wr_req,
  input  logic [NUM_PORTS-1:0]        port_rd_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_wr_addr,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_rd_addr,
  input  logic [NUM_PORTS*BLEN_W-1:0] port_wr_blen,
  input  logic [NUM_PORTS*BLEN_W-1:0] port_rd_blen,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wr_data,
  output logic [NUM_PORTS-1:0]        port_wr_ack,
  output logic [NUM_PORTS-1:0]        port_rd_ack,
  output logic [DATA_W-1:0]           port_rd_data,
  output logic                        sdram_wr_req,
  output logic                        sdram_rd_req,
  output logic [ADDR_W-1:0]           sdram_wr_addr,
  output logic [ADDR_W-1:0]           sdram_rd_addr,
  output logic [BLEN_W-1:0]           sdram_wr_blen,
  output logic [BLEN_W-1:0]           sdram_rd_blen,
  output logic [DATA_W-1:0]           sdram_wr_data,
  input  logic                        sdram_wr_ack,
  input  logic                        sdram_rd_ack,
  input  logic [DATA_W-1:0]           sdram_rd_data,
  output logic [ARB_PTR_W-1:0]        grant_port,
  output logic                        grant_rd,
  output logic                        arb_busy,
  output logic                        timeout_err
);

  localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [ARB_PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ARB_PTR_W-1:0] grant_port_q, grant_port_d;
  logic                 grant_rd_q, grant_rd_d;
  logic                 wr_req_q, wr_req_d;
  logic                 rd_req_q, rd_req_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;

  // ---------------------------------------------------------------- arbitration
  logic [NUM_PORTS-1:0] pick_req;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic                 pick_valid;
  logic [ARB_PTR_W-1:0] win_idx;
  logic                 win_wr;

`ifdef ARB_GLOBAL_WR_PRIO_EN
  // Readers only compete when no client has a write pending.
  assign pick_req = (|port_wr_req) ? port_wr_req : port_rd_req;
`else
  assign pick_req = port_wr_req | port_rd_req;
`endif

  rr_picker #(
    .N (NUM_PORTS)
  ) u_rr_picker (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // The winner takes its write if it has one; in the global-priority build the
  // picked client always has a write whenever any write is pending, so the
  // same rule yields the right direction in both builds.
  always_comb begin
    win_idx = '0;
    win_wr  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick_gnt[p]) begin
        win_idx = ARB_PTR_W'(p);
        win_wr  = port_wr_req[p];
      end
    end
  end

  // ---------------------------------------------------------------- grant muxes
  logic gnt_wr_lvl;
  logic gnt_rd_lvl;
  logic gnt_req_lvl;
  logic gnt_ack;

  always_comb begin
    sdram_wr_addr = port_wr_addr[ADDR_W-1:0];
    sdram_rd_addr = port_rd_addr[ADDR_W-1:0];
    sdram_wr_blen = port_wr_blen[BLEN_W-1:0];
    sdram_rd_blen = port_rd_blen[BLEN_W-1:0];
    sdram_wr_data = port_wr_data[DATA_W-1:0];
    gnt_wr_lvl    = port_wr_req[0];
    gnt_rd_lvl    = port_rd_req[0];
    for (int p = 1; p < NUM_PORTS; p++) begin
      if (grant_port_q == ARB_PTR_W'(p)) begin
        sdram_wr_addr = port_wr_addr[p*ADDR_W +: ADDR_W];
        sdram_rd_addr = port_rd_addr[p*ADDR_W +: ADDR_W];
        sdram_wr_blen = port_wr_blen[p*BLEN_W +: BLEN_W];
        sdram_rd_blen = port_rd_blen[p*BLEN_W +: BLEN_W];
        sdram_wr_data = port_wr_data[p*DATA_W +: DATA_W];
        gnt_wr_lvl    = port_wr_req[p];
        gnt_rd_lvl    = port_rd_req[p];
      end
    end
  end

  // Only the granted direction counts; a stray ack in the other direction is ignored.
  assign gnt_req_lvl = grant_rd_q ? gnt_rd_lvl : gnt_wr_lvl;
  assign gnt_ack     = grant_rd_q ? sdram_rd_ack : sdram_wr_ack;

  // Zero-latency ack routing: the client FIFO enables hang off these.
  always_comb begin
    port_wr_ack = '0;
    port_rd_ack = '0;
    if (state_q == ARB_GRANT || state_q == ARB_BURST) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant_port_q == ARB_PTR_W'(p)) begin
          port_wr_ack[p] = !grant_rd_q && sdram_wr_ack;
          port_rd_ack[p] = grant_rd_q && sdram_rd_ack;
        end
      end
    end
  end

  assign port_rd_data = sdram_rd_data;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_port_d  = grant_port_q;
    grant_rd_d    = grant_rd_q;
    wr_req_d      = wr_req_q;
    rd_req_d      = rd_req_q;
    timeout_err_d = 1'b0;
    to_cnt_d      = to_cnt_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d      = ARB_GRANT;
          grant_port_d = win_idx;
          grant_rd_d   = !win_wr;
          wr_req_d     = win_wr;
          rd_req_d     = !win_wr;
          to_cnt_d     = '0;
        end
      end

      ARB_GRANT: begin
        if (gnt_ack) begin
          state_d  = ARB_BURST;
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
        end else if (!gnt_req_lvl) begin
          // Client withdrew before the controller started: no turn consumed.
          state_d  = ARB_IDLE;
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          // Abandoned grant: move the pointer past this client so a dead
          // request cannot monopolise the controller.
          state_d       = ARB_IDLE;
          wr_req_d      = 1'b0;
          rd_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          rr_ptr_d      = ptr_next(grant_port_q, NUM_PORTS);
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ARB_BURST: begin
        // Grant is locked: client requests are not looked at here.
        if (!gnt_ack) begin
          state_d  = ARB_GAP;
          rr_ptr_d = ptr_next(grant_port_q, NUM_PORTS);
        end
      end

      ARB_GAP: begin
        // Lets the client FIFO level settle before its request is re-sampled.
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      grant_port_q  <= '0;
      grant_rd_q    <= 1'b0;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_port_q  <= grant_port_d;
      grant_rd_q    <= grant_rd_d;
      wr_req_q      <= wr_req_d;
      rd_req_q      <= rd_req_d;
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign sdram_wr_req = wr_req_q;
  assign sdram_rd_req = rd_req_q;
  assign grant_port   = grant_port_q;
  assign grant_rd     = grant_rd_q;
  assign arb_busy     = (state_q != ARB_IDLE);
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb/tb_sdram_port_arb.sv - randomized scoreboard bench for sdram_port_arb
module tb_sdram_port_arb;

  localparam int N  = 2;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BW = 10;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    port_wr_req = '0, port_rd_req = '0;
  logic [N*AW-1:0] port_wr_addr = '0, port_rd_addr = '0;
  logic [N*BW-1:0] port_wr_blen = '0, port_rd_blen = '0;
  logic [N*DW-1:0] port_wr_data = '0;
  logic [N-1:0]    port_wr_ack, port_rd_ack;
  logic [DW-1:0]   port_rd_data;
  logic            sdram_wr_req, sdram_rd_req;
  logic [AW-1:0]   sdram_wr_addr, sdram_rd_addr;
  logic [BW-1:0]   sdram_wr_blen, sdram_rd_blen;
  logic [DW-1:0]   sdram_wr_data;
  logic            sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
  logic [DW-1:0]   sdram_rd_data = '0;
  logic [1:0]      grant_port;
  logic            grant_rd, arb_busy, timeout_err;

  always #5 clk = ~clk;

  sdram_port_arb #(
    .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .port_wr_req(port_wr_req), .port_rd_req(port_rd_req),
    .port_wr_addr(port_wr_addr), .port_rd_addr(port_rd_addr),
    .port_wr_blen(port_wr_blen), .port_rd_blen(port_rd_blen),
    .port_wr_data(port_wr_data),
    .port_wr_ack(port_wr_ack), .port_rd_ack(port_rd_ack), .port_rd_data(port_rd_data),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .sdram_wr_blen(sdram_wr_blen), .sdram_rd_blen(sdram_rd_blen),
    .sdram_wr_data(sdram_wr_data),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack), .sdram_rd_data(sdram_rd_data),
    .grant_port(grant_port), .grant_rd(grant_rd), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            port;
    bit            rd;
    logic [AW-1:0] addr;
    logic [BW-1:0] blen;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: pending requests per client, round-robin pointer.
  bit            wr_pend[N], rd_pend[N];
  logic [AW-1:0] wr_addr_m[N], rd_addr_m[N];
  logic [BW-1:0] wr_blen_m[N], rd_blen_m[N];
  logic [DW-1:0] wdata[N];
  int            rr_m     = 0;
  int            next_lat = 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic apply_ports();
    for (int q = 0; q < N; q++) begin
      port_wr_req[q]             = wr_pend[q];
      port_rd_req[q]             = rd_pend[q];
      port_wr_addr[q*AW +: AW]   = wr_addr_m[q];
      port_rd_addr[q*AW +: AW]   = rd_addr_m[q];
      port_wr_blen[q*BW +: BW]   = wr_blen_m[q];
      port_rd_blen[q*BW +: BW]   = rd_blen_m[q];
      port_wr_data[q*DW +: DW]   = wdata[q];
    end
  endtask

  task automatic add_req(input int q, input bit rd, input logic [AW-1:0] a, input logic [BW-1:0] bl);
    if (rd) begin rd_pend[q] = 1; rd_addr_m[q] = a; rd_blen_m[q] = bl; end
    else    begin wr_pend[q] = 1; wr_addr_m[q] = a; wr_blen_m[q] = bl; end
    apply_ports();
  endtask

  function automatic bit any_pending();
    bit r = 0;
    for (int q = 0; q < N; q++) r |= wr_pend[q] | rd_pend[q];
    return r;
  endfunction

  // Winner from the arbitration rules: scan clients from rr_m upward.
  task automatic model_pick(output int p, output bit rd);
    bit found = 0;
    int q;
    p = 0; rd = 0;
    for (int i = 0; i < N; i++) begin
      q = (rr_m + i) % N;
      if (!found) begin
`ifdef ARB_GLOBAL_WR_PRIO_EN
        if (wr_pend[q]) begin p = q; rd = 0; found = 1; end
`else
        if (wr_pend[q])      begin p = q; rd = 0; found = 1; end
        else if (rd_pend[q]) begin p = q; rd = 1; found = 1; end
`endif
      end
    end
`ifdef ARB_GLOBAL_WR_PRIO_EN
    for (int i = 0; i < N; i++) begin
      q = (rr_m + i) % N;
      if (!found && rd_pend[q]) begin p = q; rd = 1; found = 1; end
    end
`endif
  endtask

  // mode 0 = controller acks a full burst, 1 = client withdraws, 2 = no ack (timeout)
  task automatic run_round(input int mode, input int rst_beat);
    int   p, lat, d, blen;
    bit   rd, seen;
    exp_t e;
    model_pick(p, rd);
    e.port = p; e.rd = rd;
    e.addr = rd ? rd_addr_m[p] : wr_addr_m[p];
    e.blen = rd ? rd_blen_m[p] : wr_blen_m[p];
    exp_q.push_back(e);
    apply_ports();
    seen = 0; lat = 0;
    while (!seen && lat < 10) begin
      @(negedge clk); lat++;
      if (sdram_wr_req || sdram_rd_req) seen = 1;
    end
    check("req_latency", lat, next_lat);
    next_lat = 1;
    if (!seen) return;

    if (mode == 0) begin
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(negedge clk);
        check("req_hold", rd ? sdram_rd_req : sdram_wr_req, 1);
      end
      blen = int'(e.blen);
      if (rd) sdram_rd_ack = 1'b1; else sdram_wr_ack = 1'b1;
      for (int b = 0; b < blen; b++) begin
        if (b == rst_beat) begin
          rst = 1'b1;
          @(negedge clk); #1;
          check("rst_wr_req", sdram_wr_req, 0);
          check("rst_rd_req", sdram_rd_req, 0);
          check("rst_wr_acks", port_wr_ack, 0);
          check("rst_rd_acks", port_rd_ack, 0);
          check("rst_busy", arb_busy, 0);
          check("rst_grant_port", grant_port, 0);
          check("rst_grant_rd", grant_rd, 0);
          sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
          for (int q = 0; q < N; q++) begin wr_pend[q] = 0; rd_pend[q] = 0; end
          rr_m = 0;
          apply_ports();
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        for (int q = 0; q < N; q++) wdata[q] = DW'($urandom);
        sdram_rd_data = DW'($urandom);
        apply_ports();
        #1;
        for (int q = 0; q < N; q++) begin
          check("wr_ack_route", port_wr_ack[q], (q == p) && !rd);
          check("rd_ack_route", port_rd_ack[q], (q == p) && rd);
        end
        if (rd) check("rd_addr_track", sdram_rd_addr, rd_addr_m[p]);
        else begin
          check("wr_addr_track", sdram_wr_addr, wr_addr_m[p]);
          check("wr_data_mux", sdram_wr_data, wdata[p]);
        end
        check("rd_data_bcast", port_rd_data, sdram_rd_data);
        if (b == 1) check("req_fall", sdram_wr_req | sdram_rd_req, 0);
        @(negedge clk);
        if (rd) rd_addr_m[p] = rd_addr_m[p] + 1'b1;
        else    wr_addr_m[p] = wr_addr_m[p] + 1'b1;
      end
      sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
      if (rd) rd_pend[p] = 0; else wr_pend[p] = 0;
      apply_ports();
      rr_m = (p + 1) % N;
      next_lat = 3;
    end else if (mode == 1) begin
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      if (rd) rd_pend[p] = 0; else wr_pend[p] = 0;
      apply_ports();
      @(negedge clk);
      check("withdraw_idle", arb_busy, 0);
      check("withdraw_req", sdram_wr_req | sdram_rd_req, 0);
    end else begin
      seen = 0; lat = 0;
      while (!seen && lat < TO + 10) begin
        @(negedge clk); lat++;
        if (timeout_err) seen = 1;
      end
      check("timeout_cycles", lat, TO);
      check("timeout_req_low", sdram_wr_req | sdram_rd_req, 0);
      check("timeout_idle", arb_busy, 0);
      rr_m = (p + 1) % N;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (any_pending() && guard < 20) begin
      run_round(0, -1);
      guard++;
    end
  endtask

  // Monitor: every new request to the controller is matched against the scoreboard.
  initial begin
    bit   prev_req = 0;
    bit   prev_to  = 0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if ((sdram_wr_req || sdram_rd_req) && !prev_req) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: port %0d rd %0d with empty scoreboard", grant_port, grant_rd);
        end else begin
          e = exp_q.pop_front();
          check("grant_port", grant_port, e.port);
          check("grant_rd", grant_rd, e.rd);
          check("sdram_wr_req", sdram_wr_req, !e.rd);
          check("sdram_rd_req", sdram_rd_req, e.rd);
          check("grant_addr", e.rd ? sdram_rd_addr : sdram_wr_addr, e.addr);
          check("grant_blen", e.rd ? sdram_rd_blen : sdram_wr_blen, e.blen);
        end
      end
      if (timeout_err && prev_to) check("timeout_pulse_width", 1, 0);
      prev_req = sdram_wr_req || sdram_rd_req;
      prev_to  = timeout_err;
    end
  end

  initial begin
    int r;
    for (int q = 0; q < N; q++) begin
      wr_pend[q] = 0; rd_pend[q] = 0; wdata[q] = '0;
      wr_addr_m[q] = '0; rd_addr_m[q] = '0; wr_blen_m[q] = '0; rd_blen_m[q] = '0;
    end
    apply_ports();
    repeat (3) @(negedge clk);
    #1;
    check("reset_wr_req", sdram_wr_req, 0);
    check("reset_rd_req", sdram_rd_req, 0);
    check("reset_busy", arb_busy, 0);
    check("reset_grant_port", grant_port, 0);
    check("reset_grant_rd", grant_rd, 0);
    check("reset_timeout", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Stray acks while idle are not forwarded and start nothing.
    sdram_wr_ack = 1'b1; sdram_rd_ack = 1'b1;
    #1;
    check("idle_ack_wr", port_wr_ack, 0);
    check("idle_ack_rd", port_rd_ack, 0);
    @(negedge clk);
    check("idle_ack_busy", arb_busy, 0);
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;

    // Long write burst from port 0.
    add_req(0, 0, 24'h000100, 10'd512);
    run_round(0, -1);

    // Both ports writing continuously.
    for (int k = 0; k < 4; k++) begin
      for (int q = 0; q < N; q++)
        if (!wr_pend[q]) add_req(q, 0, AW'($urandom), BW'($urandom_range(1, 8)));
      run_round(0, -1);
    end
    drain();

    // Port 1 write and read together, then port 0 read against port 1 write.
    add_req(1, 0, AW'($urandom), 10'd4);
    add_req(1, 1, AW'($urandom), 10'd3);
    run_round(0, -1);
    run_round(0, -1);
    drain();
    add_req(0, 1, AW'($urandom), 10'd2);
    add_req(1, 0, AW'($urandom), 10'd2);
    run_round(0, -1);
    drain();

    // Withdraw before ack, then timeout with a second client waiting.
    add_req(0, 1, AW'($urandom), 10'd5);
    run_round(1, -1);
    add_req(0, 1, AW'($urandom), 10'd5);
    add_req(1, 0, AW'($urandom), 10'd5);
    run_round(2, -1);
    drain();

    // Reset in the middle of a long burst.
    add_req(0, 0, AW'($urandom), 10'd300);
    run_round(0, 100);

    // Randomized traffic.
    repeat (40) begin
      for (int q = 0; q < N; q++) begin
        if (!wr_pend[q] && $urandom_range(0, 1) == 1) add_req(q, 0, AW'($urandom), BW'($urandom_range(1, 8)));
        if (!rd_pend[q] && $urandom_range(0, 1) == 1) add_req(q, 1, AW'($urandom), BW'($urandom_range(1, 8)));
      end
      if (!any_pending()) add_req($urandom_range(0, N-1), 1'($urandom), AW'($urandom), BW'($urandom_range(1, 8)));
      r = $urandom_range(0, 99);
      run_round((r < 70) ? 0 : (r < 85) ? 1 : 2, -1);
    end
    drain();

    repeat (6) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_idle", arb_busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
